// File: rtl/vc_muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: operation codes,
// FSM states and the iteration-counter width helper.
package vc_muldiv_pkg;

  typedef enum logic [1:0] {
    VC_MULDIV_MUL   = 2'd0,
    VC_MULDIV_DIVU  = 2'd1,
    VC_MULDIV_REMU  = 2'd2,
    VC_MULDIV_MULHU = 2'd3
  } muldiv_fn_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } muldiv_state_e;

  function automatic int unsigned cnt_width(input int unsigned nbits);
    return (nbits < 2) ? 1 : $clog2(nbits);
  endfunction

endpackage

// File: rtl/vc_SeqMulDivDpath.sv
// Datapath: shift-add multiplier and restoring divider sharing one
// accumulator pair (hi/lo) and operand register; one iteration per step.
module vc_SeqMulDivDpath
  import vc_muldiv_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [1:0]         in_fn,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  output logic [p_nbits-1:0] result
);

  muldiv_fn_e         fn_q;
  logic [p_nbits-1:0] opnd_q;
  logic [p_nbits:0]   hi_q, hi_d;
  logic [p_nbits-1:0] lo_q, lo_d;

  logic               is_div, load_div;
  logic [p_nbits:0]   mul_sum;
  logic [p_nbits:0]   div_shift;
  logic [p_nbits+1:0] div_diff;
  logic               borrow;

  assign is_div   = (fn_q == VC_MULDIV_DIVU) || (fn_q == VC_MULDIV_REMU);
  assign load_div = (muldiv_fn_e'(in_fn) == VC_MULDIV_DIVU) ||
                    (muldiv_fn_e'(in_fn) == VC_MULDIV_REMU);

  // Both the adder and the subtractor evaluate every cycle so the work done
  // per iteration never depends on operand values.
  assign mul_sum   = hi_q + {1'b0, (lo_q[0] ? opnd_q : '0)};
  assign div_shift = {hi_q[p_nbits-1:0], lo_q[p_nbits-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign borrow    = div_diff[p_nbits+1];

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_div) begin
      hi_d = borrow ? div_shift : div_diff[p_nbits:0];
      lo_d = {lo_q[p_nbits-2:0], ~borrow};
    end else begin
      hi_d = {1'b0, mul_sum[p_nbits:1]};
      lo_d = {mul_sum[0], lo_q[p_nbits-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fn_q   <= VC_MULDIV_MUL;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (load) begin
      fn_q   <= muldiv_fn_e'(in_fn);
      opnd_q <= load_div ? in_b : in_a;
      lo_q   <= load_div ? in_a : in_b;
      hi_q   <= '0;
    end else if (step) begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // lo holds the product low half / quotient, hi the product high half / remainder.
  always_comb begin
    result = lo_q;
    case (fn_q)
      VC_MULDIV_MUL, VC_MULDIV_DIVU:   result = lo_q;
      VC_MULDIV_REMU, VC_MULDIV_MULHU: result = hi_q[p_nbits-1:0];
      default:                         result = lo_q;
    endcase
  end

endmodule

// File: rtl/vc_seq_muldiv.sv
// Fixed-latency unsigned multiply/divide unit with val/rdy handshakes and a
// security domain latched at request acceptance.
module vc_seq_muldiv
  import vc_muldiv_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               domain,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [1:0]         in_fn,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  output logic               out_val,
  input  logic               out_rdy,
  output logic               out_domain,
  output logic [p_nbits-1:0] out_result
);

  localparam int unsigned CntW = cnt_width(p_nbits);

  muldiv_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            domain_q;
  logic            accept, step;

  assign accept = in_val && in_rdy;
  assign step   = (state_q == StCalc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (cnt_q == '0) state_d = StDone;
      StDone:  if (out_rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshakes come from the state alone, never from data or fn.
  always_comb begin
    in_rdy  = 1'b0;
    out_val = 1'b0;
    case (state_q)
      StIdle:  in_rdy  = 1'b1;
      StDone:  out_val = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      domain_q <= 1'b0;
    end else if (accept) begin
      cnt_q    <= CntW'(p_nbits - 1);
      domain_q <= domain;
    end else if (step && cnt_q != '0) begin
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign out_domain = domain_q;

  vc_SeqMulDivDpath #(
    .p_nbits (p_nbits)
  ) u_dpath (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (step),
    .in_fn  (in_fn),
    .in_a   (in_a),
    .in_b   (in_b),
    .result (out_result)
  );

endmodule
